fix_rx_arbiter: RTL and testbench

//  N-channel successor of the single-session TOE->FIX-engine byte interface. Reads per-session
//  TOE receive FIFOs, arbitrates round-robin at FIX message granularity, and streams bytes with

---
 rtl/fix_rx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_fix_rx_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fix_rx_arbiter.sv
// fix_rx_arbiter: round-robin arbiter that merges NUM_CH TOE receive FIFOs into
// one byte stream towards fix_engine. A channel stays granted for one whole FIX
// message, so bytes of different sessions never interleave.
// Optional feature: define FIX_RX_ERR_ABORT_EN to abort the locked message on
// error_i and to mask errored channels from arbitration.
//
// state | meaning
// IDLE  | no channel locked, searching for the next requesting channel
// LOCK  | channel cur locked, FIFO reads in progress
// DRAIN | end-of-message byte read, waiting for it to leave the skid
module fix_rx_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ID_W        = 2,
  parameter int MAX_MSG_LEN = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     empty_i,
  input  logic [NUM_CH*8-1:0]   data_i,
  input  logic [NUM_CH-1:0]     error_i,
  output logic [NUM_CH-1:0]     readreq_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [7:0]            data_o,
  output logic [ID_W-1:0]       id_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  err_o,
  output logic                  busy_o
);
  localparam int CNT_W = $clog2(MAX_MSG_LEN) + 1;
  localparam logic [7:0] SOH = 8'h01;

  typedef enum logic [1:0] {IDLE, LOCK, DRAIN} state_t;
  typedef enum logic [2:0] {M_WAIT, M_FIELD, M_ONE, M_ZERO, M_ARMED} match_t;
  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } entry_t;

  state_t           state, nstate;
  match_t           mst, mst_nxt;
  logic [ID_W-1:0]  ptr, cur, gnt_idx;
  logic             gnt_found;
  logic [NUM_CH-1:0] req;
  logic             inflight, first;
  logic [CNT_W-1:0] cnt;
  entry_t           head, tail, push_e;
  logic [1:0]       count, occ;
  logic             push, mark_tail, xfer;
  logic             sel_empty, sel_err, rx_eom, rx_max, abort, end_now, stop;
  logic [7:0]       sel_data;

`ifdef FIX_RX_ERR_ABORT_EN
  assign req     = ~empty_i & ~error_i;
  assign sel_err = error_i[cur];
`else
  logic unused_error;
  assign unused_error = ^error_i;
  assign req     = ~empty_i;
  assign sel_err = 1'b0;
`endif

  assign sel_empty = empty_i[cur];
  assign sel_data  = data_i[cur*8 +: 8];
  assign valid_o   = (count != 2'd0);
  assign xfer      = valid_o & ready_i;
  assign data_o    = head.data;
  assign id_o      = cur;
  assign sop_o     = valid_o & head.sop;
  assign eop_o     = valid_o & head.eop;
  assign err_o     = valid_o & head.err;
  assign busy_o    = (state != IDLE);

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int c;
      c = (int'(ptr) + i) % NUM_CH;
      if (!gnt_found && req[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = c[ID_W-1:0];
      end
    end
  end

  // Read gating and skid push decisions for the byte arriving from the FIFO.
  always_comb begin
    occ       = count + {1'b0, inflight} - {1'b0, xfer};
    rx_eom    = (mst == M_ARMED) && (sel_data == SOH);
    rx_max    = (cnt == CNT_W'(MAX_MSG_LEN - 1));
    abort     = (state == LOCK) && sel_err;
    end_now   = (state == LOCK) && inflight && (rx_eom || rx_max);
    stop      = end_now || abort;
    readreq_o = '0;
    if (state == LOCK && !sel_empty && occ < 2'd2 && !stop)
      readreq_o[cur] = 1'b1;
    push      = 1'b0;
    push_e    = '0;
    mark_tail = 1'b0;
    if (state == LOCK && inflight) begin
      push   = 1'b1;
      push_e = {sel_data, first, rx_eom || rx_max || abort, (rx_max && !rx_eom) || abort};
    end else if (abort) begin
      // No byte in flight: terminate on the newest queued byte if it is not the
      // one currently presented (which must stay stable), else on a zero byte.
      if (count == 2'd2) mark_tail = 1'b1;
      else begin
        push   = 1'b1;
        push_e = {8'h00, first, 1'b1, 1'b1};
      end
    end
  end

  // Tag-10 detector: SOH, '1', '0', '=' arms it; the next SOH ends the message.
  always_comb begin
    mst_nxt = M_WAIT;
    if (sel_data == SOH) mst_nxt = (mst == M_ARMED) ? M_WAIT : M_FIELD;
    else begin
      case (mst)
        M_FIELD: mst_nxt = (sel_data == "1") ? M_ONE   : M_WAIT;
        M_ONE:   mst_nxt = (sel_data == "0") ? M_ZERO  : M_WAIT;
        M_ZERO:  mst_nxt = (sel_data == "=") ? M_ARMED : M_WAIT;
        M_ARMED: mst_nxt = M_ARMED;
        default: mst_nxt = M_WAIT;
      endcase
    end
  end

  // FSM next state.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (gnt_found) nstate = LOCK;
      LOCK:    if (stop) nstate = DRAIN;
      DRAIN:   if (xfer && head.eop) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM, grant and per-message tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= ID_W'(NUM_CH - 1);
      cur      <= '0;
      inflight <= 1'b0;
      first    <= 1'b0;
      cnt      <= '0;
      mst      <= M_FIELD;
    end else begin
      state    <= nstate;
      inflight <= |readreq_o;
      if (push) first <= 1'b0;
      if (state == IDLE && gnt_found) begin
        ptr   <= gnt_idx;
        cur   <= gnt_idx;
        first <= 1'b1;
        cnt   <= '0;
        mst   <= M_FIELD;
      end
      if (state == LOCK && inflight) begin
        cnt <= cnt + CNT_W'(1);
        mst <= mst_nxt;
      end
    end
  end

  // Two-entry output skid; head is the presented byte, tail the one behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, xfer})
        2'b10: begin
          if (count == 2'd0) head <= push_e;
          else tail <= push_e;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) head <= push_e;
          else begin
            head <= tail;
            tail <= push_e;
          end
        end
        default: ;
      endcase
      if (mark_tail) begin
        if (xfer) begin
          head.eop <= 1'b1;
          head.err <= 1'b1;
        end else begin
          tail.eop <= 1'b1;
          tail.err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fix_rx_arbiter.sv
// Testbench for fix_rx_arbiter: FIFO model per channel, expected bytes queued
// when messages are loaded and compared as the arbiter emits them.
module tb_fix_rx_arbiter;
  localparam int NUM_CH = 4;
  localparam int ID_W   = 2;
  localparam int MAX_LEN = 32;
  localparam string T2_MSG = "8=FIX.4.2|9=5|35=0|10=123|";

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   empty_i;
  logic [NUM_CH*8-1:0] data_i;
  logic [NUM_CH-1:0]   error_i;
  logic [NUM_CH-1:0]   readreq_o;
  logic                valid_o, ready_i, sop_o, eop_o, err_o, busy_o;
  logic [7:0]          data_o;
  logic [ID_W-1:0]     id_o;

  logic [7:0]  fq [NUM_CH][$];
  logic [12:0] sbq [$];
  logic [NUM_CH-1:0] force_empty;
  int n_checks = 0;
  int n_errors = 0;
  int ready_pct = 100;
  int xfers = 0;
  int cyc_now = 0;
  int first_xfer, last_xfer;
  bit sb_on = 1'b1;
  bit abort_seen = 1'b0;

  fix_rx_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W), .MAX_MSG_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .empty_i(empty_i), .data_i(data_i), .error_i(error_i),
    .readreq_o(readreq_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .id_o(id_o), .sop_o(sop_o), .eop_o(eop_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic upd_empty();
    for (int k = 0; k < NUM_CH; k++)
      empty_i[k] = (fq[k].size() == 0) || force_empty[k];
  endtask

  function automatic bit fifos_empty();
    for (int k = 0; k < NUM_CH; k++)
      if (fq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: check outputs at the falling edge, then model FIFO reads.
  task automatic step();
    logic [NUM_CH-1:0] rr;
    @(negedge clk);
    if (valid_o) begin
      if (sb_on) begin
        if (sbq.size() == 0) chk("extra_byte", 32'd1, 32'd0);
        else begin
          chk(ready_i ? "byte" : "hold", {id_o, sop_o, eop_o, err_o, data_o}, sbq[0]);
          if (ready_i) void'(sbq.pop_front());
        end
      end else if (ready_i && eop_o && err_o && id_o == 2'd2) abort_seen = 1'b1;
      if (ready_i) begin
        if (xfers == 0) first_xfer = cyc_now;
        last_xfer = cyc_now;
        xfers++;
      end
    end
    if (readreq_o != '0) begin
      chk("rr_vs_empty", readreq_o & empty_i, 0);
      chk("rr_onehot", $countones(readreq_o), 1);
    end
    rr = readreq_o;
    @(posedge clk);
    #1;
    cyc_now++;
    for (int k = 0; k < NUM_CH; k++)
      if (rr[k] && fq[k].size() != 0) data_i[k*8 +: 8] = fq[k].pop_front();
    ready_i = ($urandom_range(99) < ready_pct);
    upd_empty();
  endtask

  task automatic load(input int ch, input string s, input bit trunc, input bit expect_out);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] b;
      b = (s[i] == "|") ? 8'h01 : s[i];
      fq[ch].push_back(b);
      if (expect_out)
        sbq.push_back({ID_W'(ch), i == 0, i == s.len() - 1, trunc && (i == s.len() - 1), b});
    end
    upd_empty();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < NUM_CH; k++) fq[k].delete();
    sbq.delete();
    force_empty = '0;
    error_i = '0;
    data_i = '0;
    xfers = 0;
    upd_empty();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic run_until(input int limit, input string tag);
    int cyc;
    cyc = 0;
    while ((sbq.size() != 0 || !fifos_empty()) && cyc < limit) begin
      step();
      cyc++;
    end
    chk({tag, "_done"}, cyc < limit, 1);
    step();
    chk({tag, "_busy_idle"}, busy_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    ready_i = 1'b1;
    force_empty = '0;
    error_i = '0;
    data_i = '0;
    #1;
    chk("rst_outputs", {readreq_o, valid_o, data_o, id_o, sop_o, eop_o, err_o, busy_o}, 0);

    // T1: asynchronous reset in the middle of a message
    do_reset();
    load(2, T2_MSG, 1'b0, 1'b1);
    repeat (8) step();
    chk("t1_busy_locked", busy_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_rst_async", {readreq_o, valid_o, data_o, id_o, sop_o, eop_o, err_o, busy_o}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_rr_in_rst", {readreq_o, valid_o}, 0);
    end
    do_reset();
    repeat (3) step();
    chk("t1_idle_after", {valid_o, busy_o}, 0);

    // T2: single message on ch2, back-to-back output
    do_reset();
    load(2, T2_MSG, 1'b0, 1'b1);
    run_until(200, "t2");
    chk("t2_count", xfers, T2_MSG.len());
    chk("t2_b2b", last_xfer - first_xfer, T2_MSG.len() - 1);

    // T3: round-robin order across ch0, ch1, ch3
    do_reset();
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < NUM_CH; c++)
        if (c != 2) load(c, $sformatf("8=FIX|49=C%0d|34=%0d|10=%03d|", c, n, 10 * c + n), 1'b0, 1'b1);
    run_until(600, "t3");

    // T4: random backpressure, ch1 empty mid-message, ch2 must wait
    do_reset();
    ready_pct = 50;
    load(1, T2_MSG, 1'b0, 1'b1);
    load(2, "8=FIX|49=S2|10=222|", 1'b0, 1'b1);
    load(1, "8=FIX|49=S1|10=111|", 1'b0, 1'b1);
    repeat (10) step();
    force_empty[1] = 1'b1;
    upd_empty();
    repeat (10) step();
    force_empty[1] = 1'b0;
    upd_empty();
    run_until(2000, "t4");
    ready_pct = 100;

    // T5: message without tag 10 is cut at MAX_LEN bytes
    do_reset();
    load(3, "8=FIX.4.2|9=99|35=D|55=ABCDEFGHI", 1'b1, 1'b1);
    load(3, "JK|10=000|", 1'b0, 1'b1);
    run_until(500, "t5");

    // T6: error pulse on ch2 while it is locked
    do_reset();
`ifdef FIX_RX_ERR_ABORT_EN
    sb_on = 1'b0;
    load(2, T2_MSG, 1'b0, 1'b0);
`else
    load(2, T2_MSG, 1'b0, 1'b1);
    load(3, "8=FIX|49=S3|10=033|", 1'b0, 1'b1);
`endif
    begin
      int cyc;
      cyc = 0;
      while (xfers < 4 && cyc < 100) begin
        step();
        cyc++;
      end
      chk("t6_reach_byte5", cyc < 100, 1);
    end
    error_i[2] = 1'b1;
    step();
    error_i[2] = 1'b0;
`ifdef FIX_RX_ERR_ABORT_EN
    repeat (4) step();
    chk("t6_abort_eop", abort_seen, 1);
    sb_on = 1'b1;
    do_reset();
`else
    run_until(500, "t6");
    chk("t6_count", xfers, T2_MSG.len() + 19);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
